agc_shift_ctrl: RTL and testbench

- Closes the loop on the per-window peak magnitude produced by the signed peak detector; the detector measures and this block acts.
- Once per detection window it takes the latched peak magnitude and steps a power-of-two gain (arithmetic left shift) up or down against hysteresis thresholds.
- It applies that gain, with saturation, to the same signed sample stream.
- Placement: between the DDC output and downstream quantisation/packing. The peak detector taps the ungained input of this block.

---
 rtl/agc_pkg.sv | 36 +++
 rtl/agc_sat_shift.sv | 84 ++++++++
 rtl/agc_shift_ctrl.sv | 120 ++++++++++++
 tb/tb_agc_shift_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// Shared definitions for the AGC shift controller: FSM encodings,
// width helper and saturation constants.
package agc_pkg;

  // Control FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EVAL   = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    EVAL   = ST_EVAL,
    UPDATE = ST_UPDATE,
    HOLD   = ST_HOLD
  } agc_state_e;

  // Bits needed to hold values 0..n (i.e. clog2(n+1)), never less than 1.
  function automatic int shift_width(input int n);
    int w;
    w = 1;
    while ((1 << w) <= n) w = w + 1;
    return w;
  endfunction

  // Largest positive two's-complement value of width w, as a bit pattern.
  function automatic logic [31:0] sat_pos(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Most negative two's-complement value of width w, as a bit pattern.
  function automatic logic [31:0] sat_neg(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/agc_sat_shift.sv
// Two-stage gain datapath: stage 1 captures a sample together with the
// shift in force at that moment, stage 2 applies the arithmetic left
// shift and clamps to the signed output range. Capturing the shift with
// the sample guarantees a sample never sees two different gains.
module agc_sat_shift
  import agc_pkg::*;
#(
  parameter int INPUT_WIDTH = 16,
  parameter int MAX_SHIFT   = 4,
  parameter int SHIFT_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   nd,
  input  logic [INPUT_WIDTH-1:0] data_in,
  input  logic [SHIFT_W-1:0]     shift,
  output logic                   nd_out,
  output logic [INPUT_WIDTH-1:0] data_out,
  output logic                   sat
);

  localparam int WW = INPUT_WIDTH + MAX_SHIFT;

  localparam logic [31:0]            SAT_POS_32 = sat_pos(INPUT_WIDTH);
  localparam logic [31:0]            SAT_NEG_32 = sat_neg(INPUT_WIDTH);
  localparam logic [INPUT_WIDTH-1:0] SAT_POS    = SAT_POS_32[INPUT_WIDTH-1:0];
  localparam logic [INPUT_WIDTH-1:0] SAT_NEG    = SAT_NEG_32[INPUT_WIDTH-1:0];

  logic [INPUT_WIDTH-1:0] s1_data;
  logic [SHIFT_W-1:0]     s1_shift;
  logic                   s1_nd;

  logic signed [WW-1:0]   s1_ext;
  logic signed [WW-1:0]   shifted;
  logic [MAX_SHIFT:0]     top_bits;
  logic                   ovf;

  // Stage 1: capture sample and its gain only when a new sample arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data  <= '0;
      s1_shift <= '0;
      s1_nd    <= 1'b0;
    end else begin
      s1_nd <= nd;
      if (nd) begin
        s1_data  <= data_in;
        s1_shift <= shift;
      end
    end
  end

  // Widen, shift, and detect overflow: the result fits only when every
  // bit from the output sign position upward agrees with the sign.
  always_comb begin
    s1_ext   = {{MAX_SHIFT{s1_data[INPUT_WIDTH-1]}}, s1_data};
    shifted  = s1_ext <<< s1_shift;
    top_bits = shifted[WW-1:INPUT_WIDTH-1];
    ovf      = !((&top_bits) || !(|top_bits));
  end

  // Stage 2: register the clamped result; data_out holds between samples
  always_ff @(posedge clk) begin
    if (rst) begin
      nd_out   <= 1'b0;
      data_out <= '0;
      sat      <= 1'b0;
    end else begin
      nd_out <= s1_nd;
      if (s1_nd) begin
        if (ovf) begin
          data_out <= shifted[WW-1] ? SAT_NEG : SAT_POS;
          sat      <= 1'b1;
        end else begin
          data_out <= shifted[INPUT_WIDTH-1:0];
          sat      <= 1'b0;
        end
      end else begin
        sat <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/agc_shift_ctrl.sv
// Automatic gain control by power-of-two steps. Once per detection window
// the latched peak magnitude is projected through the current gain and
// compared against hysteresis thresholds; the shift moves by at most one
// step per window, and a few windows are skipped after each change so the
// detector can observe the new gain before it is judged again.
//
// Handshake: max_valid and nd are single-cycle qualifiers with no
// back-pressure; max_valid is consumed only in IDLE (HOLD counts it),
// nd is always accepted and reappears as nd_out exactly two cycles later.
module agc_shift_ctrl
  import agc_pkg::*;
#(
  parameter int                     INPUT_WIDTH  = 16,
  parameter int                     MAX_SHIFT    = 4,
  parameter int                     INIT_SHIFT   = 0,
  parameter logic [INPUT_WIDTH-1:0] HI_TH        = 16'h6000,
  parameter logic [INPUT_WIDTH-1:0] LO_TH        = 16'h2000,
  parameter int                     HOLD_WINDOWS = 2,
  localparam int                    SHIFT_W      = shift_width(MAX_SHIFT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_WIDTH-1:0] max_in,
  input  logic                   max_valid,
  input  logic                   freeze,
  input  logic                   nd,
  input  logic [INPUT_WIDTH-1:0] data_in,
  output logic                   nd_out,
  output logic [INPUT_WIDTH-1:0] data_out,
  output logic                   sat,
  output logic [SHIFT_W-1:0]     shift_out,
  output logic [1:0]             state_dbg
);

  localparam int PW     = INPUT_WIDTH + MAX_SHIFT;
  localparam int HOLD_W = shift_width(HOLD_WINDOWS);

  localparam logic [SHIFT_W-1:0] MAX_SHIFT_V  = SHIFT_W'(MAX_SHIFT);
  localparam logic [SHIFT_W-1:0] INIT_SHIFT_V = SHIFT_W'(INIT_SHIFT);
  localparam logic [HOLD_W-1:0]  HOLD_INIT    = HOLD_W'(HOLD_WINDOWS);
  localparam logic [HOLD_W-1:0]  HOLD_LAST    = HOLD_W'(1);
  localparam logic [PW-1:0]      HI_EXT       = {{MAX_SHIFT{1'b0}}, HI_TH};
  localparam logic [PW-1:0]      LO_EXT       = {{MAX_SHIFT{1'b0}}, LO_TH};

  agc_state_e         state;
  logic [SHIFT_W-1:0] shift;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [PW-1:0]      proj;
  logic               dec;
  logic               inc;

  // Control FSM: project, compare, step the shift, then hold off
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= INIT_SHIFT_V;
      hold_cnt <= '0;
      proj     <= '0;
      dec      <= 1'b0;
      inc      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (max_valid && !freeze) begin
            proj  <= {{MAX_SHIFT{1'b0}}, max_in} << shift;
            state <= EVAL;
          end
        end
        EVAL: begin
          // Equality with either threshold is deliberately a no-change
          dec   <= (proj > HI_EXT) && (shift != '0);
          inc   <= (proj < LO_EXT) && (shift < MAX_SHIFT_V);
          state <= UPDATE;
        end
        UPDATE: begin
          if (dec) begin
            shift <= shift - 1'b1;
          end else if (inc) begin
            shift <= shift + 1'b1;
          end
          if ((dec || inc) && (HOLD_WINDOWS != 0)) begin
            hold_cnt <= HOLD_INIT;
            state    <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          // Windows measured across the gain change are not trusted
          if (hold_cnt == '0) begin
            state <= IDLE;
          end else if (max_valid) begin
            hold_cnt <= hold_cnt - 1'b1;
            if (hold_cnt == HOLD_LAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign shift_out = shift;
  assign state_dbg = state;

  agc_sat_shift #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .MAX_SHIFT   (MAX_SHIFT),
    .SHIFT_W     (SHIFT_W)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .nd       (nd),
    .data_in  (data_in),
    .shift    (shift),
    .nd_out   (nd_out),
    .data_out (data_out),
    .sat      (sat)
  );

endmodule

// File: tb/tb_agc_shift_ctrl.sv
// Directed bench for agc_shift_ctrl: gain stepping, hysteresis, hold-off,
// freeze, EVAL-time drops, reset, and the saturating datapath checked
// through an expected-value queue.
module tb_agc_shift_ctrl;
  import agc_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] max_in;
  logic        max_valid;
  logic        freeze;
  logic        nd;
  logic [15:0] data_in;
  logic        nd_out;
  logic [15:0] data_out;
  logic        sat;
  logic [2:0]  shift_out;
  logic [1:0]  state_dbg;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int model_shift = 0;

  // {sat, data_out} expected for each sample sent
  logic [16:0] exp_q[$];
  logic [16:0] exp_e;

  agc_shift_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .max_in    (max_in),
    .max_valid (max_valid),
    .freeze    (freeze),
    .nd        (nd),
    .data_in   (data_in),
    .nd_out    (nd_out),
    .data_out  (data_out),
    .sat       (sat),
    .shift_out (shift_out),
    .state_dbg (state_dbg)
  );

  // Clock and safety timeout
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no_finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference gain: exact product, then clamp to 16-bit signed
  function automatic logic [16:0] model(input logic [15:0] d, input int sh);
    longint v;
    v = longint'($signed(d)) * (longint'(1) << sh);
    if (v > 32767)  return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(v)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_max(input logic [15:0] v);
    max_in    = v;
    max_valid = 1'b1;
    tick(1);
    max_valid = 1'b0;
  endtask

  // Pulse then wait until the 3rd edge, where any new shift is visible
  task automatic eval_pulse(input logic [15:0] v);
    pulse_max(v);
    tick(2);
  endtask

  task automatic consume_hold();
    repeat (2) begin
      pulse_max(16'h0800);
      tick(1);
    end
  endtask

  task automatic send(input logic [15:0] d);
    nd      = 1'b1;
    data_in = d;
    exp_q.push_back(model(d, model_shift));
    tick(1);
    nd = 1'b0;
  endtask

  // Scoreboard: every nd_out must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (nd_out) begin
      check("sb_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("sb_data", 32'(data_out), 32'(exp_e[15:0]));
        check("sb_sat", 32'(sat), 32'(exp_e[16]));
      end
    end
  end

  initial begin
    rst = 1'b1; max_in = '0; max_valid = 1'b0; freeze = 1'b0; nd = 1'b0; data_in = '0;
    tick(2);
    check("rst_shift", 32'(shift_out), 32'd0);
    check("rst_nd_out", 32'(nd_out), 32'd0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;

    // Gain up with hold-off, then a projection landing exactly on LO_TH
    eval_pulse(16'h0800);
    check("up1_shift", 32'(shift_out), 32'd1);
    check("up1_state", 32'(state_dbg), 32'(ST_HOLD));
    consume_hold();
    check("up1_held_shift", 32'(shift_out), 32'd1);
    check("up1_hold_done", 32'(state_dbg), 32'(ST_IDLE));
    eval_pulse(16'h0800);
    check("up2_shift", 32'(shift_out), 32'd2);
    consume_hold();
    eval_pulse(16'h0800);
    check("lo_equal_shift", 32'(shift_out), 32'd2);
    check("lo_equal_state", 32'(state_dbg), 32'(ST_IDLE));
    model_shift = 2;

    // Datapath at shift 2, including two-cycle latency and hold of data_out
    send(16'h0100);
    check("lat_nd_out_1", 32'(nd_out), 32'd0);
    tick(1);
    check("lat_nd_out_2", 32'(nd_out), 32'd1);
    check("lat_data", 32'(data_out), 32'h0400);
    tick(1);
    check("lat_nd_out_drop", 32'(nd_out), 32'd0);
    check("lat_data_hold", 32'(data_out), 32'h0400);
    send(16'h1000);
    send(16'h3000);
    send(16'hD000);
    send(16'hF000);
    tick(4);
    check("sb_drain_s2", 32'(exp_q.size()), 32'd0);

    // Gain down, and no underflow at shift 0
    eval_pulse(16'h2000);
    check("down1_shift", 32'(shift_out), 32'd1);
    consume_hold();
    eval_pulse(16'h7000);
    check("down0_shift", 32'(shift_out), 32'd0);
    consume_hold();
    check("down0_held", 32'(shift_out), 32'd0);
    eval_pulse(16'h7000);
    check("floor_shift", 32'(shift_out), 32'd0);
    check("floor_state", 32'(state_dbg), 32'(ST_IDLE));

    // Climb to MAX_SHIFT, then no overflow past it
    for (int i = 0; i < 4; i++) begin
      eval_pulse(16'h0001);
      check("climb_shift", 32'(shift_out), 32'(i + 1));
      consume_hold();
    end
    eval_pulse(16'h0001);
    check("ceil_shift", 32'(shift_out), 32'd4);
    check("ceil_state", 32'(state_dbg), 32'(ST_IDLE));

    // Freeze blocks evaluation
    freeze = 1'b1;
    pulse_max(16'h7000);
    tick(3);
    check("freeze_shift", 32'(shift_out), 32'd4);
    check("freeze_state", 32'(state_dbg), 32'(ST_IDLE));
    freeze = 1'b0;
    model_shift = 4;

    // Datapath at shift 4
    send(16'h0800);
    send(16'h0100);
    send(16'hFF80);
    send(16'hF800);
    tick(4);
    check("sb_drain_s4", 32'(exp_q.size()), 32'd0);

    // A max_valid arriving during EVAL is dropped: one update only
    max_in    = 16'h7000;
    max_valid = 1'b1;
    tick(1);
    check("eval_state", 32'(state_dbg), 32'(ST_EVAL));
    tick(1);
    max_valid = 1'b0;
    tick(1);
    check("evaldrop_shift", 32'(shift_out), 32'd3);
    check("evaldrop_state", 32'(state_dbg), 32'(ST_HOLD));
    tick(3);
    check("hold_waits", 32'(state_dbg), 32'(ST_HOLD));
    consume_hold();
    check("evaldrop_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("evaldrop_final", 32'(shift_out), 32'd3);

    // Reset in the middle of HOLD with samples streaming
    eval_pulse(16'h7000);
    check("pre_rst_shift", 32'(shift_out), 32'd2);
    check("pre_rst_state", 32'(state_dbg), 32'(ST_HOLD));
    model_shift = 2;
    send(16'h1000);
    rst     = 1'b1;
    nd      = 1'b1;
    data_in = 16'h3000;
    exp_q.delete();
    tick(1);
    check("mid_rst_shift", 32'(shift_out), 32'd0);
    check("mid_rst_nd_out", 32'(nd_out), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_sat", 32'(sat), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    tick(1);
    rst = 1'b0;
    nd  = 1'b0;
    model_shift = 0;
    tick(2);
    check("post_rst_nd_out", 32'(nd_out), 32'd0);
    eval_pulse(16'h0800);
    check("post_rst_eval", 32'(shift_out), 32'd1);
    model_shift = 1;
    send(16'h4000);
    send(16'hC000);
    tick(4);
    check("sb_drain_final", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
